// File: rtl/ldpc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ldpc_pkg
//  Description : Definitions shared by the LDPC node-processor datapath blocks
//                (augmented_adder_tree, extrinsic_distributor): the one-hot
//                sequencing states and a constant-foldable clog2 helper.
//  Revision    : 1.0  initial release
// ============================================================================
package ldpc_pkg;

  // One-hot sequencing states shared by the node-processor blocks.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    EMIT = 3'b010,
    DONE = 3'b100
  } state_e;

  // Ceiling log2, usable in parameter and localparam expressions.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/extrinsic_distributor_sat_sub.sv
`default_nettype none
// ============================================================================
//  Module      : sat_sub
//  Description : Unsigned subtractor that clamps at zero. Combinational only.
//  Ports       : a_i     - minuend
//                b_i     - subtrahend
//                y_o     - a_i - b_i, or 0 when b_i > a_i
//                uflow_o - high when b_i > a_i
//  Revision    : 1.0  initial release
// ============================================================================
module sat_sub #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o,
  output logic         uflow_o
);

  assign uflow_o = (b_i > a_i);
  assign y_o     = uflow_o ? '0 : (a_i - b_i);

endmodule
`default_nettype wire

// File: rtl/extrinsic_distributor.sv
`default_nettype none
// ============================================================================
//  Module      : extrinsic_distributor
//  Description : Serial extrinsic-message generator. Latches the adder-tree
//                total and the message vector on start, then streams
//                sum - msg[i] (clamped at 0) for i = 0..INPUTS_NUM-1 over a
//                valid/ready handshake, and pulses done after the last
//                transfer. Underflow on any accepted transfer sets a sticky
//                err flag that is cleared by reset or the next start.
//  Ports       : clk, rst_n (async, active-low)
//                start      - load request, honoured only in IDLE
//                sum_in     - adder-tree total
//                input_data - packed message bus, msg i at [i*WIDTH +: WIDTH]
//                out_data / out_index / out_valid / out_ready - output stream
//                busy       - high in EMIT and DONE
//                done       - one-cycle pulse after the final transfer
//                err        - sticky underflow flag
//  Revision    : 1.0  initial release
// ============================================================================
module extrinsic_distributor
  import ldpc_pkg::*;
#(
  parameter  int WIDTH      = 5,
  parameter  int INPUTS_NUM = 8,
  localparam int STAGES     = clog2(INPUTS_NUM),
  localparam int IDX_W      = (clog2(INPUTS_NUM) < 1) ? 1 : clog2(INPUTS_NUM)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [WIDTH+STAGES-1:0]     sum_in,
  input  logic [INPUTS_NUM*WIDTH-1:0] input_data,
  output logic [WIDTH+STAGES-1:0]     out_data,
  output logic [IDX_W-1:0]            out_index,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int              SW       = WIDTH + STAGES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUTS_NUM - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic [SW-1:0]    sum_q;
  logic [WIDTH-1:0] msg_q [INPUTS_NUM];
  logic             uflow_q;   // underflow status of the value on out_data

  logic [SW-1:0]    sub_a;
  logic [SW-1:0]    sub_b;
  logic [SW-1:0]    sub_y;
  logic             sub_uflow;

  // The outputs are registered, so the subtractor always works one value
  // ahead: in IDLE it prepares entry 0 straight from the input bus, in EMIT
  // it prepares the entry after the one currently presented.
  always_comb begin
    idx_d = idx_q + IDX_W'(1);
    sub_a = sum_q;
    sub_b = '0;
    if (state_q == IDLE) begin
      sub_a = sum_in;
      sub_b = SW'(input_data[WIDTH-1:0]);
    end else begin
      // Explicit compare keeps the select in range for non-power-of-two sizes.
      for (int i = 0; i < INPUTS_NUM; i++) begin
        if (idx_d == IDX_W'(i)) sub_b = SW'(msg_q[i]);
      end
    end
  end

  sat_sub #(
    .W (SW)
  ) u_sat_sub (
    .a_i     (sub_a),
    .b_i     (sub_b),
    .y_o     (sub_y),
    .uflow_o (sub_uflow)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      sum_q     <= '0;
      for (int i = 0; i < INPUTS_NUM; i++) msg_q[i] <= '0;
      uflow_q   <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sum_q <= sum_in;
            for (int i = 0; i < INPUTS_NUM; i++) msg_q[i] <= input_data[i*WIDTH +: WIDTH];
            idx_q     <= '0;
            err       <= 1'b0;
            out_data  <= sub_y;
            uflow_q   <= sub_uflow;
            out_index <= '0;
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state_q   <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (uflow_q) err <= 1'b1;
            if (idx_q == LAST_IDX) begin
              out_valid <= 1'b0;
              out_data  <= '0;
              out_index <= '0;
              uflow_q   <= 1'b0;
              done      <= 1'b1;
              state_q   <= DONE;
            end else begin
              idx_q     <= idx_d;
              out_index <= idx_d;
              out_data  <= sub_y;
              uflow_q   <= sub_uflow;
            end
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
          out_data  <= '0;
          out_index <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
